// File: rtl/fpaddsub_norm_shift_pkg.sv
// ---------------------------------------------------------------------------
// fpaddsub_pkg
// Shared widths, constants and the FSM state type for the post-addition
// normalizer of the single-precision add/sub datapath.
// ---------------------------------------------------------------------------
package fpaddsub_pkg;

    localparam int EXP_W  = 8;    // IEEE754 single exponent width
    localparam int MANT_W = 25;   // raw sum: carry + hidden one + 23 fraction
    localparam int SIG_W  = 24;   // normalized significand incl. hidden one

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : fpaddsub_pkg

// File: rtl/fpaddsub_norm_shift_lzc25.sv
// ---------------------------------------------------------------------------
// fpaddsub_lzc25
// Combinational 25-bit leading-zero counter. Counts zeros starting at bit 24.
// An all-zero input returns 25.
//   data_i  [24:0]  vector to examine
//   count_o [4:0]   number of leading zeros (0..25)
// ---------------------------------------------------------------------------
module fpaddsub_lzc25 (
    input  logic [24:0] data_i,
    output logic [4:0]  count_o
);

    // Scan from LSB upward so the most significant set bit is the last
    // (and therefore winning) assignment.
    always_comb begin
        count_o = 5'd25;
        for (int i = 0; i < 25; i++) begin
            if (data_i[i]) begin
                count_o = 5'(24 - i);
            end
        end
    end

endmodule : fpaddsub_lzc25

// File: rtl/fpaddsub_norm_shift.sv
// ---------------------------------------------------------------------------
// fpaddsub_norm_shift
// Post-addition normalizer: restores the hidden one of a raw mantissa sum.
// A carry-out is fixed with a one-bit right shift; cancellation is fixed with
// an iterative left shift of at most STEP bits per cycle. The exponent is
// adjusted accordingly and overflow / underflow (flush to zero) are flagged.
// Results leave through a valid/ready handshake to the rounding stage.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready high only in IDLE)
//   in_sign             sign, passed through
//   in_exp  [7:0]       common exponent from alignment
//   in_mant [24:0]      raw sum (bit24 carry, bit23 hidden-one position)
//   in_g, in_ps         guard and pre-sticky from alignment
//   out_valid/out_ready output handshake
//   out_sign, out_exp, out_mant[23:0], out_g, out_s   normalized result
//   out_zero, out_ovf, out_unf                        result class flags
// ---------------------------------------------------------------------------
module fpaddsub_norm_shift
    import fpaddsub_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_g,
    input  logic              in_ps,

    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [SIG_W-1:0]  out_mant,
    output logic              out_g,
    output logic              out_s,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_unf
);

    localparam logic [4:0] STEP_C = 5'(STEP);

    // -----------------------------------------------------------------------
    // State and working registers
    // -----------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [MANT_W-1:0] w_q, w_d;        // left-aligned working mantissa + guard
    logic [EXP_W:0]    e_q, e_d;        // 9-bit working exponent
    logic              s_q, s_d;        // sticky carried through the shift

    logic              out_valid_q, out_valid_d;
    logic              out_sign_q,  out_sign_d;
    logic [EXP_W-1:0]  out_exp_q,   out_exp_d;
    logic [SIG_W-1:0]  out_mant_q,  out_mant_d;
    logic              out_g_q,     out_g_d;
    logic              out_s_q,     out_s_d;
    logic              out_zero_q,  out_zero_d;
    logic              out_ovf_q,   out_ovf_d;
    logic              out_unf_q,   out_unf_d;

    // -----------------------------------------------------------------------
    // Leading-zero count of the working register
    // -----------------------------------------------------------------------
    logic [4:0] lzc;

    fpaddsub_lzc25 u_lzc (
        .data_i  (w_q),
        .count_o (lzc)
    );

    // Per-cycle shift amount, capped at STEP
    logic [4:0]        shift_k;
    logic [MANT_W-1:0] w_shifted;
    logic [EXP_W:0]    e_shifted;
    logic [EXP_W:0]    exp_inc;

    always_comb begin
        shift_k   = (lzc > STEP_C) ? STEP_C : lzc;
        w_shifted = w_q << shift_k;
        e_shifted = e_q - {4'd0, shift_k};
        exp_inc   = {1'b0, in_exp} + 9'd1;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        e_d         = e_q;
        s_d         = s_q;
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_mant_d  = out_mant_q;
        out_g_d     = out_g_q;
        out_s_d     = out_s_q;
        out_zero_d  = out_zero_q;
        out_ovf_d   = out_ovf_q;
        out_unf_d   = out_unf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Every accept starts from a clean result record so stale
                    // flags from the previous transaction never leak through.
                    out_sign_d = in_sign;
                    out_exp_d  = '0;
                    out_mant_d = '0;
                    out_g_d    = 1'b0;
                    out_s_d    = 1'b0;
                    out_zero_d = 1'b0;
                    out_ovf_d  = 1'b0;
                    out_unf_d  = 1'b0;

                    if (in_mant[24]) begin
                        // Carry-out: one-bit right shift, exponent + 1
                        if (exp_inc == {1'b0, EXP_MAX}) begin
                            out_exp_d = EXP_MAX;
                            out_ovf_d = 1'b1;
                        end else begin
                            out_exp_d  = exp_inc[EXP_W-1:0];
                            out_mant_d = in_mant[24:1];
                            out_g_d    = in_mant[0];
                            out_s_d    = in_g | in_ps;
                        end
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if ({in_mant[23:0], in_g} == '0) begin
                        // Exact cancellation; the pre-sticky is reported but
                        // does not make the result nonzero.
                        out_s_d     = in_ps;
                        out_zero_d  = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (in_mant[23]) begin
                        // Already normalized
                        out_exp_d   = in_exp;
                        out_mant_d  = in_mant[23:0];
                        out_g_d     = in_g;
                        out_s_d     = in_ps;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        // Cancellation: the guard bit joins the mantissa so it
                        // is shifted in as a real significand bit.
                        w_d     = {in_mant[23:0], in_g};
                        e_d     = {1'b0, in_exp};
                        s_d     = in_ps;
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                // Compare against the full count, not the capped step, so an
                // underflow is caught on the first shift cycle.
                if ({4'd0, lzc} >= e_q) begin
                    out_exp_d   = '0;
                    out_mant_d  = '0;
                    out_g_d     = 1'b0;
                    out_s_d     = 1'b0;
                    out_unf_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    w_d = w_shifted;
                    e_d = e_shifted;
                    if (w_shifted[24]) begin
                        out_exp_d   = e_shifted[EXP_W-1:0];
                        out_mant_d  = w_shifted[24:1];
                        out_g_d     = w_shifted[0];
                        out_s_d     = s_q;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            w_q         <= '0;
            e_q         <= '0;
            s_q         <= 1'b0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_mant_q  <= '0;
            out_g_q     <= 1'b0;
            out_s_q     <= 1'b0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            e_q         <= e_d;
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_mant_q  <= out_mant_d;
            out_g_q     <= out_g_d;
            out_s_q     <= out_s_d;
            out_zero_q  <= out_zero_d;
            out_ovf_q   <= out_ovf_d;
            out_unf_q   <= out_unf_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_exp   = out_exp_q;
    assign out_mant  = out_mant_q;
    assign out_g     = out_g_q;
    assign out_s     = out_s_q;
    assign out_zero  = out_zero_q;
    assign out_ovf   = out_ovf_q;
    assign out_unf   = out_unf_q;

endmodule : fpaddsub_norm_shift

// File: tb/tb_fpaddsub_norm_shift.sv
// ---------------------------------------------------------------------------
// tb_fpaddsub_norm_shift
// Directed, table-driven bench for the post-addition normalizer (STEP=8),
// plus hand-written sequences for backpressure and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_fpaddsub_norm_shift;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        in_g;
    logic        in_ps;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [23:0] out_mant;
    logic        out_g;
    logic        out_s;
    logic        out_zero;
    logic        out_ovf;
    logic        out_unf;

    int n_cmp;
    int n_err;

    fpaddsub_norm_shift #(.STEP(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_g      (in_g),
        .in_ps     (in_ps),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_g     (out_g),
        .out_s     (out_s),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] mant;
        logic        g;
        logic        ps;
        int          lat;
        logic [7:0]  e_exp;
        logic [23:0] e_mant;
        logic        e_g;
        logic        e_s;
        logic        e_zero;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic drive_in(input vec_t v);
        in_sign = v.sign;
        in_exp  = v.exp;
        in_mant = v.mant;
        in_g    = v.g;
        in_ps   = v.ps;
    endtask

    // Waits for out_valid; latency counted so that a result registered on
    // the accept edge itself reports 1. Bounded at 20 cycles.
    task automatic wait_valid(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic chk_result(input vec_t v, input string tag);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".sign"},  {31'd0, out_sign},  {31'd0, v.sign});
        chk({tag, ".exp"},   {24'd0, out_exp},   {24'd0, v.e_exp});
        chk({tag, ".mant"},  {8'd0, out_mant},   {8'd0, v.e_mant});
        chk({tag, ".g"},     {31'd0, out_g},     {31'd0, v.e_g});
        chk({tag, ".s"},     {31'd0, out_s},     {31'd0, v.e_s});
        chk({tag, ".flags"}, {29'd0, out_zero, out_ovf, out_unf},
                             {29'd0, v.e_zero, v.e_ovf, v.e_unf});
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        drive_in(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(lat);
        chk({tag, ".latency"}, lat, v.lat);
        chk_result(v, tag);
        $display("txn %s: exp=%h mant=%h g=%b s=%b z/o/u=%b%b%b lat=%0d",
                 tag, out_exp, out_mant, out_g, out_s, out_zero, out_ovf, out_unf, lat);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".drain_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".drain_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        vec_t alt;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_g      = 1'b0;
        in_ps     = 1'b0;
        out_ready = 1'b0;

        //            sign exp    mant          g     ps    lat e_exp  e_mant        eg    es    ez    eo    eu
        vecs[0]  = '{1'b0, 8'h80, 25'h1800000, 1'b1, 1'b0, 1, 8'h81, 24'hC00000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h80, 25'h0000001, 1'b0, 1'b0, 4, 8'h69, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h05, 25'h0000100, 1'b0, 1'b0, 2, 8'h00, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 8'hFE, 25'h1000000, 1'b1, 1'b1, 1, 8'hFF, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h40, 25'h0000000, 1'b0, 1'b1, 1, 8'h00, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h7F, 25'h0ABCDEF, 1'b1, 1'b0, 1, 8'h7F, 24'hABCDEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h10, 25'h0400001, 1'b1, 1'b1, 2, 8'h0F, 24'h800003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h80, 25'h0000000, 1'b1, 1'b0, 4, 8'h68, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h01, 25'h0400000, 1'b0, 1'b0, 2, 8'h00, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 8'h02, 25'h0400000, 1'b0, 1'b0, 2, 8'h01, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'hFD, 25'h1FFFFFF, 1'b0, 1'b0, 1, 8'hFE, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst.valid",  {31'd0, out_valid}, 32'd0);
        chk("rst.ready",  {31'd0, in_ready},  32'd1);
        chk("rst.exp",    {24'd0, out_exp},   32'd0);
        chk("rst.mant",   {8'd0, out_mant},   32'd0);
        chk("rst.flags",  {27'd0, out_zero, out_ovf, out_unf, out_g, out_s}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held while out_ready=0; new input ignored
        alt = vecs[5];
        @(negedge clk);
        drive_in(vecs[0]);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(lat);
        chk("bp.latency", lat, 1);
        drive_in(alt);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_result(vecs[0], $sformatf("bp.hold%0d", c));
            chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp.release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp.release_ready", {31'd0, in_ready},  32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp.no_capture", {31'd0, out_valid}, 32'd0);
        end
        $display("txn backpressure: held 5 cycles, ignored input not captured");

        // Reset during the second SHIFT cycle
        @(negedge clk);
        drive_in(vecs[1]);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rs.valid", {31'd0, out_valid}, 32'd0);
        chk("rs.ready", {31'd0, in_ready},  32'd1);
        chk("rs.exp",   {24'd0, out_exp},   32'd0);
        chk("rs.mant",  {8'd0, out_mant},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs.idle_valid", {31'd0, out_valid}, 32'd0);
        $display("txn reset_in_shift: in-flight result discarded");
        run_vec(vecs[1], "rs.after");

        // Reset while a result is waiting in DONE
        @(negedge clk);
        drive_in(vecs[0]);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(lat);
        chk("rd.pre_valid", {31'd0, out_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rd.valid", {31'd0, out_valid}, 32'd0);
        chk("rd.ready", {31'd0, in_ready},  32'd1);
        chk("rd.mant",  {8'd0, out_mant},   32'd0);
        chk("rd.exp",   {24'd0, out_exp},   32'd0);
        chk("rd.s",     {31'd0, out_s},     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset_in_done: held result discarded");
        run_vec(vecs[6], "rd.after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fpaddsub_norm_shift
